// File: rtl/dmem_resp.sv
// Word-addressed data memory slave with fixed response latency.
// Each request is captured in IDLE and answered with a one-cycle ack after LATENCY edges.
module dmem_resp #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for req; captures addr/we/wdata when req=1
  // WAIT  | latency countdown on the captured transaction
  // RESP  | ack cycle; rdata/err valid, write commits at the edge leaving it
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                we_q, fault_q;
  logic [DEPTH_W-1:0]  idx_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W-1:0]   mem [2**DEPTH_W];
  logic                accept, addr_fault, resp_entry;

  assign accept     = (state == IDLE) && req;
  assign addr_fault = (addr[1:0] != 2'b00) || ((addr >> (DEPTH_W + 2)) != '0);
  assign resp_entry = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we;
      fault_q <= addr_fault;
      idx_q   <= addr[DEPTH_W+1:2];
      wdata_q <= wdata;
    end
  end

  // Read data is registered on entry to RESP and cleared on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  rdata_q <= '0;
    else if (resp_entry && !we_q && !fault_q) rdata_q <= mem[idx_q];
    else                                      rdata_q <= '0;
  end

  always_ff @(posedge clk) begin
    if ((state == RESP) && we_q && !fault_q) mem[idx_q] <= wdata_q;
  end

  assign ack   = (state == RESP);
  assign err   = ack && fault_q;
  assign rdata = rdata_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboarded random test of dmem_resp against an array memory model,
// plus latency sweep instances at LATENCY=1 and 15.
module tb_dmem_resp;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          ackedge;
  } exp_t;

  logic clk = 0, rst = 0;
  logic req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ack, err, busy;
  logic [31:0] rdata;

  logic lreq = 0, lwe = 0;
  logic [31:0] laddr = 0, lwdata = 0;
  logic ack1, err1, busy1, ack15, err15, busy15;
  logic [31:0] rdata1, rdata15;

  int edge_n = 0;
  int tests = 0, fails = 0;
  int last_ack = -100;
  bit no_mon = 0;
  exp_t q[$];
  logic [31:0] mem_m [256];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  dmem_resp #(.DATA_W(32), .DEPTH_W(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy));

  dmem_resp #(.DATA_W(32), .DEPTH_W(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(lreq), .we(lwe), .addr(laddr), .wdata(lwdata),
    .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1));

  dmem_resp #(.DATA_W(32), .DEPTH_W(8), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .req(lreq), .we(lwe), .addr(laddr), .wdata(lwdata),
    .ack(ack15), .rdata(rdata15), .err(err15), .busy(busy15));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares each ack against the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && !no_mon) begin
      logic exp_busy;
      exp_busy = (q.size() > 0) && (edge_n >= q[0].acc) && (edge_n <= q[0].ackedge);
      chk("busy", 32'(busy), 32'(exp_busy));
      if (ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", 32'(err), 32'(e.err));
          chk("ack_edge", 32'(edge_n), 32'(e.ackedge));
        end
      end else begin
        chk("idle_rdata", rdata, 32'd0);
        chk("idle_err", 32'(err), 32'd0);
      end
    end
  end

  // Issue one transaction (called at negedge+1); waits for its ack.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input bit keep);
    exp_t e;
    bit   flt, got;
    flt = (a[1:0] != 2'b00) || ((a >> 10) != 0);
    req = 1; we = w; addr = a; wdata = d;
    e.acc     = (edge_n + 1 > last_ack + 2) ? edge_n + 1 : last_ack + 2;
    e.ackedge = e.acc + LAT;
    e.err     = flt;
    e.rdata   = (w || flt) ? 32'd0 : mem_m[a[9:2]];
    if (w && !flt) mem_m[a[9:2]] = d;
    last_ack = e.ackedge;
    q.push_back(e);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    #1;
    if (!keep) req = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    else if (r == 1) return $urandom | 32'h0000_0400;
    else             return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  initial begin
    logic [31:0] saved;
    int acc;
    #1 rst = 1;
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 0;

    for (int i = 0; i < 256; i++) do_txn(1'b1, 32'(i * 4), $urandom, 1'b1);
    req = 0;
    @(negedge clk); #1;

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 1'b0);
    do_txn(1'b1, 32'h13, 32'h1, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 1'b0);
    do_txn(1'b0, 32'h400, 32'h0, 1'b0);
    @(negedge clk); #1;

    for (int i = 0; i < 3; i++) do_txn(1'b0, 32'(i * 4 + 8), 32'h0, 1'b1);
    req = 0;

    for (int i = 0; i < 200; i++) begin
      bit keep;
      keep = 1'($urandom);
      do_txn(1'($urandom), rand_addr(), $urandom, keep);
      if (!keep) repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
    end
    req = 0;
    @(negedge clk); #1;

    // Reset during WAIT of a write to 0x20 must abort it.
    saved = mem_m[8];
    no_mon = 1;
    req = 1; we = 1; addr = 32'h20; wdata = 32'h55;
    @(negedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1; req = 0;
    #1;
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    no_mon = 0;
    last_ack = -100;
    repeat (4) begin @(negedge clk); #1; end
    do_txn(1'b0, 32'h20, 32'h0, 1'b0);
    chk("abort_mem_model", mem_m[8], saved);

    // Latency sweep; req withdrawn right after acceptance.
    @(negedge clk); #1;
    no_mon = 1;
    lreq = 1; lwe = 1; laddr = 32'h4; lwdata = 32'hA5A5_0001;
    acc = edge_n + 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("l1_busy", 32'(busy1), 32'((edge_n >= acc) && (edge_n <= acc + 1)));
      chk("l1_ack", 32'(ack1), 32'(edge_n == acc + 1));
      chk("l15_busy", 32'(busy15), 32'((edge_n >= acc) && (edge_n <= acc + 15)));
      chk("l15_ack", 32'(ack15), 32'(edge_n == acc + 15));
      chk("l_err", 32'(err1 | err15), 32'd0);
      #1;
      if (k == 0) lreq = 0;
    end
    no_mon = 0;

    if (q.size() != 0) chk("pending_left", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data and address width in bits.
REQ-002 The block SHALL have parameter DEPTH_W, default 8, meaning log2 of the word count (256 words).
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning wait cycles before response; legal range 1..15.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous assert, active-high.
REQ-006 Port req  input  1  initiator request; held high with addr/we/wdata stable until ack.
REQ-007 Port we  input  1  1 = word write, 0 = word read.
REQ-008 Port addr  input  DATA_W  byte address of the access.
REQ-009 Port wdata  input  DATA_W  write data.
REQ-010 Port ack  output  1  one-cycle response pulse ending a transaction.
REQ-011 Port rdata  output  DATA_W  read data, valid while ack=1 for a read.
REQ-012 Port err  output  1  access fault, valid while ack=1.
REQ-013 Port busy  output  1  high while a transaction is in flight (state != IDLE).

Function
REQ-014 Storage SHALL be 2^DEPTH_W words of DATA_W bits, indexed by addr[DEPTH_W+1:2]; contents not reset.
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 In IDLE with req=1 at a rising edge: capture addr, we, wdata; load counter with LATENCY-1; go to WAIT.
REQ-017 In WAIT: counter != 0 -> decrement; counter == 0 -> go to RESP.
REQ-018 ack SHALL be high for exactly the one cycle in RESP, i.e. the cycle starting LATENCY edges after the accepting edge.
REQ-019 RESP SHALL return to IDLE at the next edge unconditionally; a new request is accepted no earlier than the edge after that.
REQ-020 req, we, addr, wdata SHALL be ignored outside IDLE; the captured copies are used for the whole transaction.
REQ-021 A request withdrawn during WAIT (protocol violation) SHALL still complete normally with ack.
REQ-022 Fault: err=1 with ack when captured addr[1:0] != 0 or addr[DATA_W-1:DEPTH_W+2] != 0.
REQ-023 Read, no fault: rdata = mem[index] during the ack cycle, err=0.
REQ-024 Read with fault: rdata = 0 during ack.
REQ-025 Write, no fault: mem[index] <= captured wdata at the edge ending RESP; rdata = 0 during ack.
REQ-026 Write with fault: memory SHALL be unmodified.
REQ-027 A read accepted after a write's ack SHALL return the written value (read-after-write).
REQ-028 rdata and err SHALL be 0 whenever ack=0.
REQ-029 ack, rdata, err, busy SHALL be driven from registers or decoded state only, with no combinational path from req/addr/we/wdata.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, counter 0, ack=0, err=0, rdata=0, busy=0.
REQ-031 Reset during WAIT or RESP SHALL abort the transaction: no ack and no memory write.
REQ-032 After rst falls, a request SHALL be accepted at the first rising edge with req=1.

Verification
REQ-033 Write then read, LATENCY=2: write addr=0x10, wdata=0xDEADBEEF, accepted at edge 0 -> ack in cycle after edge 2, err=0; read addr=0x10 -> ack with rdata=0xDEADBEEF, err=0.
REQ-034 Misaligned: write addr=0x13, wdata=0x1 -> ack with err=1; read addr=0x10 -> rdata still 0xDEADBEEF.
REQ-035 Out of range, DEPTH_W=8: read addr=0x400 -> ack with err=1, rdata=0.
REQ-036 Latency sweep, LATENCY=1 and 15: ack SHALL appear exactly 1 and 15 edges after acceptance; busy high from acceptance through the ack cycle.
REQ-037 Reset mid-write: write addr=0x20, wdata=0x55; pulse rst during WAIT -> no ack, all outputs 0; later read 0x20 -> value unchanged from before the write.
REQ-038 Back-to-back: req held high across 3 reads -> one ack per transaction; each acceptance at the edge after the previous RESP->IDLE edge (period LATENCY+2 cycles).
